// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned INSTR_BYTES      = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~(INSTR_BYTES - 32'd1);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Memory read port, redirect request and instruction handshake between fetch unit and core.
interface fetch_unit_if;

    logic [31:0] mem_addr;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    modport master (
        output mem_addr,
        output mem_rstrb,
        input  mem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc
    );

    modport slave (
        input  mem_addr,
        input  mem_rstrb,
        output mem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Instruction buffer: power-of-two ring of {instr, pc} entries with push, pop and flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push_i,
    input  fetch_entry_t             data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output fetch_entry_t             head_o,
    output logic [$clog2(Depth):0]   count_o,
    output logic                     empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    fetch_entry_t    mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    always_comb begin
        // Flush wins: a push or pop in the same cycle is dropped.
        do_push  = push_i && !flush_i;
        do_pop   = pop_i && !flush_i && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction prefetcher: credit-based read issue, one-cycle memory latency,
// buffered delivery to the core, and redirect that flushes everything in flight.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input logic          clk,
    input logic          resetn,
    fetch_unit_if.master bus
);

    localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned UsedW = CntW + 1;
    localparam logic [UsedW-1:0] DepthU = UsedW'(FIFO_DEPTH);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      issue_pc_q;
    logic             inflight_q;
    logic             issue;
    logic [UsedW-1:0] used;

    logic             fifo_push, fifo_pop, fifo_empty;
    logic [CntW-1:0]  fifo_count;
    fetch_entry_t     fifo_head, push_entry;

    assign fifo_pop   = !fifo_empty && bus.instr_ready;
    // A response returning in a redirect cycle belongs to the abandoned stream.
    assign fifo_push  = inflight_q && !bus.redirect_valid;
    assign push_entry = '{instr: bus.mem_rdata, pc: issue_pc_q};

    // Credit: buffered + in-flight - leaving this cycle must stay below capacity.
    always_comb begin
        used  = {1'b0, fifo_count} + {{CntW{1'b0}}, inflight_q} - {{CntW{1'b0}}, fifo_pop};
        issue = resetn && !bus.redirect_valid && (used < DepthU);
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (bus.redirect_valid) begin
            fetch_pc_d = align_word(bus.redirect_pc);
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + INSTR_BYTES;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
            issue_pc_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= issue;
            issue_pc_q <= bus.mem_addr;
        end
    end

    fetch_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (fifo_push),
        .data_i  (push_entry),
        .pop_i   (fifo_pop),
        .flush_i (bus.redirect_valid),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    assign bus.mem_addr    = align_word(fetch_pc_q);
    assign bus.mem_rstrb   = issue;
    assign bus.instr_valid = !fifo_empty;
    assign bus.instr       = fifo_empty ? '0 : fifo_head.instr;
    assign bus.instr_pc    = fifo_empty ? '0 : fifo_head.pc;

endmodule
